ff_bank_universal: RTL and testbench
====================================

// Module: ff_bank_universal
// PURPOSE
//  WIDTH-channel bank of run-time configurable flip-flops. Each channel acts as a D, T, JK or SR
//  flip-flop, selected per channel by a programmable mode register. Adds a global clock enable,
//  a parametrised reset value and a parametrised resolution of the illegal SR input (S=R=1).
//  Illegal SR events are logged in sticky per-channel flags and a saturating event counter.
//  Sits wherever mixed storage-element behaviour is needed behind one uniform interface.
// PARAMETERS
//  WIDTH        4       number of channels
//  CNT_W        8       width of the illegal-event counter
//  RESET_Q      '0      WIDTH-bit value loaded into q on reset
//  DEFAULT_MODE 2'b00   mode loaded into every channel on reset
//  SR_ILLEGAL   0       S=R=1 resolution: 0 = hold, 1 = reset-dominant (q<=0), 2 = set-dominant (q<=1)
// PORTS
//  clk       in   1         rising-edge clock
//  rst       in   1         synchronous, active-high reset
//  en        in   1         global update enable; 0 = every q holds
//  cfg_we    in   1         load cfg_mode into the mode register
//  cfg_mode  in   2*WIDTH   channel i mode = cfg_mode[2i+1:2i]
//  a         in   WIDTH     per-channel D / T / J / S input
//  b         in   WIDTH     per-channel K / R input (ignored in D and T modes)
//  err_clr   in   1         clear sr_err and err_cnt
//  q         out  WIDTH     channel state
//  q_n       out  WIDTH     ~q (combinational)
//  mode      out  2*WIDTH   current mode register
//  sr_err    out  WIDTH     sticky: channel saw S=R=1 while in SR mode with en=1
//  err_cnt   out  CNT_W     count of cycles with >=1 illegal SR event; saturates at 2^CNT_W-1
// BEHAVIOUR
//  - Reset (rst=1 at posedge; overrides every other input): q<=RESET_Q, mode<=DEFAULT_MODE on all
//    channels, sr_err<=0, err_cnt<=0. Reset applied mid-sequence discards all state in that cycle.
//  - Mode encoding: 00 D, 01 T, 10 JK, 11 SR.
//  - Next-state rules, applied when en=1, 1-cycle latency (q updates at the edge after inputs):
//      D : q<=a
//      T : q<=a ? ~q : q
//      JK: 00 hold, 01 q<=0, 10 q<=1, 11 q<=~q   ({J,K}={a,b})
//      SR: 00 hold, 01 q<=0, 10 q<=1, 11 per SR_ILLEGAL   ({S,R}={a,b})
//  - en=0: q holds, no illegal event is detected, sr_err and err_cnt change only through err_clr.
//  - cfg_we=1: mode<=cfg_mode at that edge. The q update in the same cycle uses the OLD mode; the
//    new mode governs from the next edge on. cfg_we is independent of en.
//  - Illegal event for channel i: en & mode_i==SR & a[i] & b[i]. It sets sr_err[i] at the edge.
//    err_cnt increments by exactly 1 for each cycle with any illegal event (not per channel) and
//    holds at all-ones once saturated.
//  - err_clr=1 with no illegal event in the same cycle: sr_err<=0, err_cnt<=0.
//  - err_clr=1 with a simultaneous illegal event: the event wins. sr_err<=event vector and
//    err_cnt<=1.
//  - JK 11 and T toggle every enabled cycle without limit. No glitch is possible on q_n.
// STRUCTURE
//  - Package ff_bank_pkg holds the mode localparams MODE_D/MODE_T/MODE_JK/MODE_SR (2-bit) and the
//    SR_HOLD/SR_RST_DOM/SR_SET_DOM encodings for SR_ILLEGAL.
//  - Sub-module ff_cell_universal: one channel's q register, its next-state mux and its illegal
//    detect. It takes clk, rst, en, mode[1:0], a, b and the per-cell reset value, and drives q and
//    illegal.
//  - Top level generates WIDTH cells and also holds the mode register, the sr_err flags and the
//    err_cnt counter.
// TESTING
//  1. Reset with RESET_Q=4'b1010 and DEFAULT_MODE=00: q=1010, mode=0, sr_err=0, err_cnt=0. Next
//     cycle, en=1 and a=0101: q=0101.
//  2. cfg_mode=JK,T,SR,D (ch3..0), en=1, a=1111, b=1111 for 3 cycles. Ch3 toggles each cycle.
//     Ch2 toggles each cycle. Ch1 follows SR_ILLEGAL (0: holds) with sr_err[1]=1 and err_cnt=3.
//     Ch0 =1.
//  3. Same cycle: cfg_we=1 to switch ch0 D->T, plus a[0]=1. q0 loads 1 (old D rule). On the next
//     edge with a[0]=1, q0 toggles to 0.
//  4. en=0 for 4 cycles with random a/b and SR illegal inputs: q, sr_err and err_cnt are unchanged.
//  5. CNT_W=2, illegal input held for 6 cycles: err_cnt goes 1,2,3,3,3,3. Then err_clr with an
//     illegal input in the same cycle: err_cnt=1, sr_err=event vector.
//  6. rst asserted mid-toggle with mixed modes: the next edge gives RESET_Q/DEFAULT_MODE, flags
//     cleared. Repeat for SR_ILLEGAL=1 (q<=0) and SR_ILLEGAL=2 (q<=1) on S=R=1.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - mode and SR-illegal encodings shared by the flip-flop bank
package ff_bank_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  localparam int SR_HOLD    = 0;
  localparam int SR_RST_DOM = 1;
  localparam int SR_SET_DOM = 2;

  // State taken by an SR cell when S=R=1, given the chosen resolution.
  function automatic logic sr_resolve(input int res, input logic q);
    if (res == SR_RST_DOM) return 1'b0;
    if (res == SR_SET_DOM) return 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/ff_cell_universal.sv
// rtl/ff_cell_universal.sv - one run-time configurable D/T/JK/SR flip-flop channel
module ff_cell_universal
  import ff_bank_pkg::*;
#(
  parameter int SR_ILLEGAL = SR_HOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  input  logic       rst_val,
  output logic       q,
  output logic       illegal
);

  logic q_nxt;

  always_comb begin
    q_nxt   = q;
    illegal = 1'b0;
    if (en) begin
      case (mode)
        MODE_D:  q_nxt = a;
        MODE_T:  q_nxt = a ? ~q : q;
        MODE_JK: begin
          case ({a, b})
            2'b00:   q_nxt = q;
            2'b01:   q_nxt = 1'b0;
            2'b10:   q_nxt = 1'b1;
            default: q_nxt = ~q;
          endcase
        end
        default: begin
          case ({a, b})
            2'b00:   q_nxt = q;
            2'b01:   q_nxt = 1'b0;
            2'b10:   q_nxt = 1'b1;
            default: begin
              q_nxt   = sr_resolve(SR_ILLEGAL, q);
              illegal = 1'b1;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) q <= rst_val;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/ff_bank_universal.sv
// rtl/ff_bank_universal.sv - WIDTH-channel configurable flip-flop bank with illegal-SR logging
module ff_bank_universal
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH        = 4,
  parameter int               CNT_W        = 8,
  parameter logic [WIDTH-1:0] RESET_Q      = '0,
  parameter logic [1:0]       DEFAULT_MODE = 2'b00,
  parameter int               SR_ILLEGAL   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [2*WIDTH-1:0] cfg_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_n,
  output logic [2*WIDTH-1:0] mode,
  output logic [WIDTH-1:0]   sr_err,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] illegal;
  logic             any_illegal;

  assign q_n         = ~q;
  assign any_illegal = |illegal;

  // Cells see the registered mode, so a cfg_we edge still updates q under the old mode.
  always_ff @(posedge clk) begin
    if (rst)         mode <= {WIDTH{DEFAULT_MODE}};
    else if (cfg_we) mode <= cfg_mode;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell_universal #(
      .SR_ILLEGAL(SR_ILLEGAL)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode[2*i+1:2*i]),
      .a       (a[i]),
      .b       (b[i]),
      .rst_val (RESET_Q[i]),
      .q       (q[i]),
      .illegal (illegal[i])
    );
  end

  // A fresh illegal event outranks err_clr so that no event is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_err  <= '0;
      err_cnt <= '0;
    end else if (any_illegal) begin
      if (err_clr) begin
        sr_err  <= illegal;
        err_cnt <= CNT_W'(1);
      end else begin
        sr_err  <= sr_err | illegal;
        if (err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      sr_err  <= '0;
      err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ff_bank_universal.sv
// tb/tb_ff_bank_universal.sv - scoreboard bench over three parameterisations of ff_bank_universal
module tb_ff_bank_universal;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_mode = 8'h00;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       err_clr = 1'b0;

  logic [3:0] q0, q1, q2, qn0, qn1, qn2, se0, se1, se2;
  logic [7:0] m0, m1, m2;
  logic [7:0] c0;
  logic [1:0] c1, c2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // DUT0: hold on S=R=1, 8-bit counter. DUT1: reset-dominant, 2-bit. DUT2: set-dominant, 2-bit.
  ff_bank_universal #(.WIDTH(4), .CNT_W(8), .RESET_Q(4'b1010), .DEFAULT_MODE(2'b00), .SR_ILLEGAL(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q0), .q_n(qn0), .mode(m0), .sr_err(se0), .err_cnt(c0));
  ff_bank_universal #(.WIDTH(4), .CNT_W(2), .RESET_Q(4'b1010), .DEFAULT_MODE(2'b00), .SR_ILLEGAL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q1), .q_n(qn1), .mode(m1), .sr_err(se1), .err_cnt(c1));
  ff_bank_universal #(.WIDTH(4), .CNT_W(2), .RESET_Q(4'b1010), .DEFAULT_MODE(2'b00), .SR_ILLEGAL(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_mode(cfg_mode), .a(a), .b(b),
    .err_clr(err_clr), .q(q2), .q_n(qn2), .mode(m2), .sr_err(se2), .err_cnt(c2));

  typedef struct {
    int         dut;
    logic [3:0] q;
    logic [7:0] mode;
    logic [3:0] err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];

  logic [3:0] m_q[3];
  logic [7:0] m_mode[3];
  logic [3:0] m_err[3];
  int         m_cnt[3];
  int         cnt_max[3] = '{255, 3, 3};
  int         sr_res[3]  = '{0, 1, 2};

  function automatic logic model_bit(input logic [1:0] md, input logic qq, input logic ai,
                                     input logic bi, input int res);
    case (md)
      2'd0: return ai;
      2'd1: return qq ^ ai;
      2'd2: return (ai & bi) ? ~qq : (ai ? 1'b1 : (bi ? 1'b0 : qq));
      default: begin
        if (ai & bi) return (res == 0) ? qq : (res == 1) ? 1'b0 : 1'b1;
        return ai ? 1'b1 : (bi ? 1'b0 : qq);
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic we, input logic [7:0] cm,
                      input logic [3:0] ai, input logic [3:0] bi, input logic clr);
    exp_t x;
    logic [3:0] ill;
    logic [3:0] nq;
    logic [3:0] obs_q, obs_qn, obs_e;
    logic [7:0] obs_m, obs_c;
    @(negedge clk);
    rst = r; en = e; cfg_we = we; cfg_mode = cm; a = ai; b = bi; err_clr = clr;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 4; i++) begin
        ill[i] = e & (m_mode[d][2*i+:2] == 2'd3) & ai[i] & bi[i];
        nq[i]  = e ? model_bit(m_mode[d][2*i+:2], m_q[d][i], ai[i], bi[i], sr_res[d]) : m_q[d][i];
      end
      if (r) begin
        m_q[d] = 4'b1010; m_mode[d] = 8'h00; m_err[d] = 4'h0; m_cnt[d] = 0;
      end else begin
        m_q[d] = nq;
        if (we) m_mode[d] = cm;
        if (ill != 4'h0) begin
          if (clr) begin m_err[d] = ill; m_cnt[d] = 1; end
          else begin
            m_err[d] = m_err[d] | ill;
            if (m_cnt[d] < cnt_max[d]) m_cnt[d] = m_cnt[d] + 1;
          end
        end else if (clr) begin
          m_err[d] = 4'h0; m_cnt[d] = 0;
        end
      end
      x.dut = d; x.q = m_q[d]; x.mode = m_mode[d]; x.err = m_err[d]; x.cnt = 8'(m_cnt[d]);
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      case (x.dut)
        0:       begin obs_q = q0; obs_qn = qn0; obs_m = m0; obs_e = se0; obs_c = c0; end
        1:       begin obs_q = q1; obs_qn = qn1; obs_m = m1; obs_e = se1; obs_c = {6'b0, c1}; end
        default: begin obs_q = q2; obs_qn = qn2; obs_m = m2; obs_e = se2; obs_c = {6'b0, c2}; end
      endcase
      check($sformatf("dut%0d_q", x.dut), {4'h0, obs_q}, {4'h0, x.q});
      check($sformatf("dut%0d_q_n", x.dut), {4'h0, obs_qn}, {4'h0, ~x.q});
      check($sformatf("dut%0d_mode", x.dut), obs_m, x.mode);
      check($sformatf("dut%0d_sr_err", x.dut), {4'h0, obs_e}, {4'h0, x.err});
      check($sformatf("dut%0d_err_cnt", x.dut), obs_c, x.cnt);
    end
  endtask

  localparam logic [7:0] MIX = 8'b10_01_11_00;   // ch3 JK, ch2 T, ch1 SR, ch0 D
  localparam logic [7:0] MIX_T0 = 8'b10_01_11_01;

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_q[d] = 4'h0; m_mode[d] = 8'h00; m_err[d] = 4'h0; m_cnt[d] = 0;
    end
    // reset, then D load
    step(1, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    step(0, 1, 0, 8'h00, 4'b0101, 4'h0, 0);
    // mixed modes, all inputs high for 3 cycles
    step(0, 0, 1, MIX, 4'h0, 4'h0, 0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 8'h00, 4'hF, 4'hF, 0);
    // ch0 D->T in same cycle as a[0]=1, then toggle under new mode
    step(0, 1, 1, MIX_T0, 4'b0001, 4'h0, 0);
    step(0, 1, 0, 8'h00, 4'b0001, 4'h0, 0);
    // disabled: nothing moves
    for (int k = 0; k < 4; k++) step(0, 0, 0, 8'h00, 4'($urandom) | 4'b0010, 4'($urandom) | 4'b0010, 0);
    // clear, then saturate with illegal ch1 for 6 cycles
    step(0, 1, 0, 8'h00, 4'h0, 4'h0, 1);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 8'h00, 4'b0010, 4'b0010, 0);
    step(0, 1, 0, 8'h00, 4'b0010, 4'b0010, 1);
    step(0, 1, 0, 8'h00, 4'h0, 4'h0, 1);
    // random mixed traffic
    for (int k = 0; k < 12; k++)
      step(0, 1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 4) == 0));
    // reset in the middle of toggling
    step(0, 1, 1, MIX, 4'h0, 4'h0, 0);
    step(0, 1, 0, 8'h00, 4'hF, 4'hF, 0);
    step(1, 1, 1, 8'hFF, 4'hF, 4'hF, 0);
    step(0, 1, 0, 8'h00, 4'b0101, 4'h0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
